// File: rtl/axi4_cfg_slave.sv
// AXI4 configuration register bank: NR_OF_RW_P read/write words followed by
// NR_OF_RO_P read-only status words. Single-beat writes, INCR read bursts,
// SLVERR for any word index beyond the implemented map.
module axi4_cfg_slave #(
    parameter int unsigned AXI4_ID_WIDTH_P   = 4,
    parameter int unsigned AXI4_ADDR_WIDTH_P = 16,
    parameter int unsigned AXI4_DATA_WIDTH_P = 32,
    parameter int unsigned AXI4_STRB_WIDTH_P = 4,
    parameter int unsigned NR_OF_RW_P        = 8,
    parameter int unsigned NR_OF_RO_P        = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [AXI4_ID_WIDTH_P-1:0]                awid,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              awaddr,
    input  logic                                      awvalid,
    output logic                                      awready,
    input  logic [AXI4_DATA_WIDTH_P-1:0]              wdata,
    input  logic [AXI4_STRB_WIDTH_P-1:0]              wstrb,
    input  logic                                      wlast,
    input  logic                                      wvalid,
    output logic                                      wready,
    output logic [AXI4_ID_WIDTH_P-1:0]                bid,
    output logic [1:0]                                bresp,
    output logic                                      bvalid,
    input  logic                                      bready,
    input  logic [AXI4_ID_WIDTH_P-1:0]                arid,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              araddr,
    input  logic [7:0]                                arlen,
    input  logic                                      arvalid,
    output logic                                      arready,
    output logic [AXI4_ID_WIDTH_P-1:0]                rid,
    output logic [AXI4_DATA_WIDTH_P-1:0]              rdata,
    output logic [1:0]                                rresp,
    output logic                                      rlast,
    output logic                                      rvalid,
    input  logic                                      rready,
    output logic [NR_OF_RW_P*AXI4_DATA_WIDTH_P-1:0]   cfg_regs,
    output logic [NR_OF_RW_P-1:0]                     cfg_wr_pulse,
    input  logic [NR_OF_RO_P*AXI4_DATA_WIDTH_P-1:0]   sts_regs
);

    localparam int unsigned OFF_W  = $clog2(AXI4_STRB_WIDTH_P);
    localparam int unsigned IDX_W  = AXI4_ADDR_WIDTH_P - OFF_W;
    localparam int unsigned NR_TOT = NR_OF_RW_P + NR_OF_RO_P;

    typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic [AXI4_DATA_WIDTH_P-1:0] regs_q [NR_OF_RW_P];

    logic [IDX_W-1:0]             wr_idx_q;
    logic [AXI4_ID_WIDTH_P-1:0]   wr_id_q;
    logic [AXI4_DATA_WIDTH_P-1:0] wr_data_q;
    logic [AXI4_STRB_WIDTH_P-1:0] wr_strb_q;
    logic                         aw_held_q;
    logic                         w_held_q;

    // Read index carries one spare bit so a burst running past the top of
    // the address map stays out of range instead of wrapping to index 0.
    logic [IDX_W:0]               rd_idx_q;
    logic [7:0]                   rd_len_q;
    logic [7:0]                   rd_cnt_q;
    logic [IDX_W:0]               rd_sel_idx;
    logic [AXI4_DATA_WIDTH_P-1:0] lk_data;
    logic                         lk_err;

    logic aw_hs;
    logic w_hs;
    logic unused_inputs;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Byte-offset address bits and wlast carry no information for this block.
    assign unused_inputs = ^{wlast, awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

    // Flatten the RW register array onto the cfg_regs bus.
    always_comb begin
        cfg_regs = '0;
        for (int unsigned i = 0; i < NR_OF_RW_P; i++) begin
            cfg_regs[i*AXI4_DATA_WIDTH_P +: AXI4_DATA_WIDTH_P] = regs_q[i];
        end
    end

    // Select the index of the beat about to be loaded and look up its data.
    always_comb begin
        if (rd_state == RD_IDLE) begin
            rd_sel_idx = {1'b0, araddr[AXI4_ADDR_WIDTH_P-1:OFF_W]};
        end else begin
            rd_sel_idx = rd_idx_q + (IDX_W+1)'(1);
        end
        lk_data = '0;
        lk_err  = 1'b1;
        for (int unsigned i = 0; i < NR_OF_RW_P; i++) begin
            if (rd_sel_idx == (IDX_W+1)'(i)) begin
                lk_data = regs_q[i];
                lk_err  = 1'b0;
            end
        end
        for (int unsigned j = 0; j < NR_OF_RO_P; j++) begin
            if (rd_sel_idx == (IDX_W+1)'(NR_OF_RW_P + j)) begin
                lk_data = sts_regs[j*AXI4_DATA_WIDTH_P +: AXI4_DATA_WIDTH_P];
                lk_err  = 1'b0;
            end
        end
    end

    // Write FSM: collect AW and W in any order, apply strobed write, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state     <= WR_IDLE;
            awready      <= 1'b0;
            wready       <= 1'b0;
            bvalid       <= 1'b0;
            bid          <= '0;
            bresp        <= '0;
            cfg_wr_pulse <= '0;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            wr_idx_q     <= '0;
            wr_id_q      <= '0;
            wr_data_q    <= '0;
            wr_strb_q    <= '0;
            for (int unsigned i = 0; i < NR_OF_RW_P; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            cfg_wr_pulse <= '0;
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        wr_idx_q  <= awaddr[AXI4_ADDR_WIDTH_P-1:OFF_W];
                        wr_id_q   <= awid;
                        aw_held_q <= 1'b1;
                        awready   <= 1'b0;
                    end else if (!aw_held_q) begin
                        awready <= 1'b1;
                    end
                    if (w_hs) begin
                        wr_data_q <= wdata;
                        wr_strb_q <= wstrb;
                        w_held_q  <= 1'b1;
                        wready    <= 1'b0;
                    end else if (!w_held_q) begin
                        wready <= 1'b1;
                    end
                    if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                        wr_state <= WR_EXEC;
                    end
                end
                WR_EXEC: begin
                    for (int unsigned i = 0; i < NR_OF_RW_P; i++) begin
                        if (wr_idx_q == IDX_W'(i)) begin
                            for (int unsigned k = 0; k < AXI4_STRB_WIDTH_P; k++) begin
                                if (wr_strb_q[k]) begin
                                    regs_q[i][k*8 +: 8] <= wr_data_q[k*8 +: 8];
                                end
                            end
                            cfg_wr_pulse[i] <= 1'b1;
                        end
                    end
                    bresp     <= ({1'b0, wr_idx_q} >= (IDX_W+1)'(NR_TOT)) ? 2'b10 : 2'b00;
                    bid       <= wr_id_q;
                    bvalid    <= 1'b1;
                    aw_held_q <= 1'b0;
                    w_held_q  <= 1'b0;
                    wr_state  <= WR_RESP;
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read FSM: capture AR, then stream arlen+1 beats with registered data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            rdata    <= '0;
            rresp    <= '0;
            rd_idx_q <= '0;
            rd_len_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (arvalid && arready) begin
                        rid      <= arid;
                        rd_idx_q <= rd_sel_idx;
                        rd_len_q <= arlen;
                        rd_cnt_q <= '0;
                        rdata    <= lk_data;
                        rresp    <= lk_err ? 2'b10 : 2'b00;
                        rlast    <= (arlen == 8'd0);
                        rvalid   <= 1'b1;
                        arready  <= 1'b0;
                        rd_state <= RD_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid   <= 1'b0;
                            rlast    <= 1'b0;
                            arready  <= 1'b1;
                            rd_state <= RD_IDLE;
                        end else begin
                            rd_idx_q <= rd_sel_idx;
                            rd_cnt_q <= rd_cnt_q + 8'd1;
                            rdata    <= lk_data;
                            rresp    <= lk_err ? 2'b10 : 2'b00;
                            rlast    <= ((rd_cnt_q + 8'd1) == rd_len_q);
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_cfg_slave.sv
// Self-checking bench for axi4_cfg_slave: reference register model plus
// scoreboards of expected B responses and R beats.
module tb_axi4_cfg_slave;

    localparam int NRW = 8;
    localparam int NRO = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         awid = '0;
    logic [15:0]        awaddr = '0;
    logic               awvalid = 1'b0;
    logic               awready;
    logic [31:0]        wdata = '0;
    logic [3:0]         wstrb = '0;
    logic               wlast = 1'b0;
    logic               wvalid = 1'b0;
    logic               wready;
    logic [3:0]         bid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready = 1'b0;
    logic [3:0]         arid = '0;
    logic [15:0]        araddr = '0;
    logic [7:0]         arlen = '0;
    logic               arvalid = 1'b0;
    logic               arready;
    logic [3:0]         rid;
    logic [31:0]        rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
    logic               rready = 1'b0;
    logic [NRW*32-1:0]  cfg_regs;
    logic [NRW-1:0]     cfg_wr_pulse;
    logic [NRO*32-1:0]  sts_regs;

    axi4_cfg_slave #(
        .AXI4_ID_WIDTH_P   (4),
        .AXI4_ADDR_WIDTH_P (16),
        .AXI4_DATA_WIDTH_P (32),
        .AXI4_STRB_WIDTH_P (4),
        .NR_OF_RW_P        (NRW),
        .NR_OF_RO_P        (NRO)
    ) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse), .sts_regs(sts_regs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bresp_t;

    rbeat_t      rq[$];
    bresp_t      bq[$];
    logic [31:0] exp_regs [NRW];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [32:0] model_word(input int idx);
        if (idx < NRW)       return {1'b0, exp_regs[idx]};
        if (idx < NRW + NRO) return {1'b0, sts_regs[(idx-NRW)*32 +: 32]};
        return {1'b1, 32'h0};
    endfunction

    task automatic drive_aw(input logic [15:0] addr, input logic [3:0] id, input int dly);
        logic rdy;
        bit   done = 0;
        repeat (dly) begin @(posedge clk); #1; end
        awaddr = addr; awid = id; awvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            rdy = awready;
            @(posedge clk); #1;
            if (rdy) begin done = 1; break; end
        end
        awvalid = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL aw_handshake: awready never seen, required 1");
        end
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        logic rdy;
        bit   done = 0;
        repeat (dly) begin @(posedge clk); #1; end
        wdata = data; wstrb = strb; wlast = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            rdy = wready;
            @(posedge clk); #1;
            if (rdy) begin done = 1; break; end
        end
        wvalid = 1'b0; wlast = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL w_handshake: wready never seen, required 1");
        end
    endtask

    // Full write transaction with independent AW/W delays and a bready hold-off.
    task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] id,
                            input int aw_dly, input int w_dly, input int bhold);
        int          idx;
        logic [7:0]  exp_pulse;
        bresp_t      be;
        bresp_t      got;
        logic        v;
        bit          done = 0;
        idx = int'(addr >> 2);
        exp_pulse = '0;
        if (idx < NRW) begin
            for (int k = 0; k < 4; k++) if (strb[k]) exp_regs[idx][k*8 +: 8] = data[k*8 +: 8];
            exp_pulse[idx] = 1'b1;
        end
        be.id = id;
        be.resp = (idx >= NRW + NRO) ? 2'b10 : 2'b00;
        bq.push_back(be);
        fork
            drive_aw(addr, id, aw_dly);
            drive_w(data, strb, w_dly);
        join
        @(posedge clk); #1;
        n_checks++;
        if (cfg_wr_pulse !== exp_pulse) begin
            n_fail++; $display("FAIL wr_pulse: got %h required %h", cfg_wr_pulse, exp_pulse);
        end
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++; $display("FAIL bvalid_latency: got %b required 1", bvalid);
        end
        for (int i = 0; i < NRW; i++) begin
            n_checks++;
            if (cfg_regs[i*32 +: 32] !== exp_regs[i]) begin
                n_fail++; $display("FAIL cfg_reg%0d: got %h required %h", i, cfg_regs[i*32 +: 32], exp_regs[i]);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (cfg_wr_pulse !== 8'h00) begin
            n_fail++; $display("FAIL wr_pulse_clear: got %h required 00", cfg_wr_pulse);
        end
        for (int c = 0; c < bhold; c++) begin
            n_checks++;
            if (bvalid !== 1'b1 || bid !== id) begin
                n_fail++; $display("FAIL b_stable: got bvalid=%b bid=%h required 1/%h", bvalid, bid, id);
            end
            @(posedge clk); #1;
        end
        bready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            v = bvalid; got.id = bid; got.resp = bresp;
            @(posedge clk); #1;
            if (v) begin done = 1; break; end
        end
        bready = 1'b0;
        be = bq.pop_front();
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL b_timeout: bvalid never seen, required 1");
        end else if (got.id !== be.id || got.resp !== be.resp) begin
            n_fail++; $display("FAIL b_resp: got id=%h resp=%0d required id=%h resp=%0d", got.id, got.resp, be.id, be.resp);
        end
        n_checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++; $display("FAIL aw_w_ready_after_b: got %b%b required 11", awready, wready);
        end
    endtask

    task automatic issue_ar(input logic [15:0] addr, input logic [7:0] len, input logic [3:0] id);
        rbeat_t b;
        logic   rdy;
        bit     done = 0;
        logic [32:0] w;
        for (int i = 0; i <= int'(len); i++) begin
            w = model_word(int'(addr >> 2) + i);
            b.data = w[31:0];
            b.resp = w[32] ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            b.id   = id;
            rq.push_back(b);
        end
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            rdy = arready;
            @(posedge clk); #1;
            if (rdy) begin done = 1; break; end
        end
        arvalid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL ar_handshake: arready never seen, required 1");
        end else if (rvalid !== 1'b1) begin
            n_fail++; $display("FAIL rvalid_latency: got %b required 1", rvalid);
        end
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input bit rnd_ready);
        rbeat_t exp;
        logic v, r, l, hl;
        logic [31:0] d, hd;
        logic [1:0]  rs, hrs;
        logic [3:0]  ri;
        bit hold = 0;
        issue_ar(addr, len, id);
        for (int c = 0; c < 400 && rq.size() > 0; c++) begin
            rready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            v = rvalid; r = rready; d = rdata; rs = rresp; l = rlast; ri = rid;
            if (v && hold) begin
                n_checks++;
                if (d !== hd || rs !== hrs || l !== hl) begin
                    n_fail++; $display("FAIL r_stable: got %h/%0d/%b required %h/%0d/%b", d, rs, l, hd, hrs, hl);
                end
            end
            @(posedge clk); #1;
            if (v && r) begin
                exp = rq.pop_front();
                hold = 0;
                n_checks++;
                if (d !== exp.data || rs !== exp.resp || l !== exp.last || ri !== exp.id) begin
                    n_fail++;
                    $display("FAIL r_beat: got data=%h resp=%0d last=%b id=%h required data=%h resp=%0d last=%b id=%h",
                             d, rs, l, ri, exp.data, exp.resp, exp.last, exp.id);
                end
                if (exp.last) begin
                    n_checks++;
                    if (arready !== 1'b1 || rvalid !== 1'b0) begin
                        n_fail++; $display("FAIL ar_ready_after_last: got arready=%b rvalid=%b required 1/0", arready, rvalid);
                    end
                end
            end else if (v) begin
                hold = 1; hd = d; hrs = rs; hl = l;
            end
        end
        rready = 1'b0;
        if (rq.size() > 0) begin
            n_checks++; n_fail++;
            $display("FAIL r_timeout: got %0d beats outstanding required 0", rq.size());
            rq.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0 || bvalid !== 1'b0 ||
            rvalid !== 1'b0 || cfg_regs !== '0 || cfg_wr_pulse !== '0 || bresp !== 2'b00 || rresp !== 2'b00) begin
            n_fail++; $display("FAIL reset_outputs: got rdy=%b%b%b bvalid=%b rvalid=%b required all 0",
                               awready, wready, arready, bvalid, rvalid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1 || cfg_regs !== '0) begin
            n_fail++; $display("FAIL reset_release: got rdy=%b%b%b required 111 with cfg_regs 0", awready, wready, arready);
        end
    endtask

    task automatic test_full_write();
        do_write(16'h0008, 32'hDEADBEEF, 4'hF, 4'h5, 0, 0, 0);
    endtask

    task automatic test_order_strobe();
        do_write(16'h000A, 32'h0000AB00, 4'h2, 4'h9, 3, 0, 5);
        do_write(16'h0004, 32'h11223344, 4'hF, 4'h1, 0, 2, 1);
    endtask

    task automatic test_burst_read();
        do_write(16'h0018, 32'h66666666, 4'hF, 4'h2, 0, 0, 0);
        do_write(16'h001C, 32'h77777777, 4'hF, 4'h3, 1, 0, 0);
        do_read(16'h0018, 8'd3, 4'hA, 1'b0);
        do_read(16'h0018, 8'd3, 4'hB, 1'b1);
    endtask

    task automatic test_errors();
        do_read(16'h002C, 8'd1, 4'h4, 1'b0);
        do_write(16'h0050, 32'hFFFFFFFF, 4'hF, 4'h6, 0, 0, 0);
        do_write(16'h0024, 32'hFFFFFFFF, 4'hF, 4'h7, 0, 0, 0);
    endtask

    task automatic test_reset_mid_burst();
        logic rdy;
        araddr = 16'h0000; arlen = 8'd3; arid = 4'hC; arvalid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            rdy = arready;
            @(posedge clk); #1;
            if (rdy) break;
        end
        arvalid = 1'b0;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rvalid !== 1'b0 || arready !== 1'b0 || rdata !== '0 || rlast !== 1'b0 || cfg_regs !== '0) begin
            n_fail++; $display("FAIL reset_mid_burst: got rvalid=%b arready=%b rdata=%h required 0/0/0", rvalid, arready, rdata);
        end
        for (int i = 0; i < NRW; i++) exp_regs[i] = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (arready !== 1'b1) begin
            n_fail++; $display("FAIL arready_after_reset: got %b required 1", arready);
        end
        do_read(16'h0018, 8'd3, 4'hD, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            do_write(16'(($urandom_range(0, NRW-1)) * 4), $urandom, 4'($urandom_range(1, 15)),
                     4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end
        do_read(16'h0000, 8'd12, 4'hE, 1'b1);
    endtask

    initial begin
        sts_regs = {32'hA5A5_0003, 32'h0BAD_F00D, 32'hCAFE_F00D, 32'h1234_5678};
        for (int i = 0; i < NRW; i++) exp_regs[i] = '0;
        test_reset();
        test_full_write();
        test_order_strobe();
        test_burst_read();
        test_errors();
        test_reset_mid_burst();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion required finish");
        $fatal(1);
    end

endmodule
